ibus_uart_tx: RTL and testbench



---
 rtl/ibus_uart_pkg.sv | 29 ++
 rtl/ibus_sync_fifo.sv | 61 ++++++
 rtl/ibus_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_ibus_uart_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibus_uart_pkg.sv
// Shared constants for the io-bus UART blocks: register offsets, status bit
// positions, serializer state encoding and the divisor floor.
package ibus_uart_pkg;

  // Register offsets within the block's 256-word window; lower offsets are data.
  localparam logic [7:0] OFS_DIV    = 8'hFE;
  localparam logic [7:0] OFS_STATUS = 8'hFF;

  // STATUS word layout.
  localparam int unsigned ST_OVF   = 15;
  localparam int unsigned ST_FULL  = 14;
  localparam int unsigned ST_EMPTY = 13;
  localparam int unsigned ST_BUSY  = 12;
  localparam int unsigned ST_CNT_W = 12;

  // Serializer states.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // Smallest usable bit time in clocks.
  localparam logic [15:0] DIV_MIN = 16'd2;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/ibus_sync_fifo.sv
// Single-clock FIFO with registered occupancy count. A push while full is
// refused even if a pop happens on the same edge.
module ibus_sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointer and count next state; pointers wrap naturally since Depth is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CntW'(1);
  end

  // Pointer and count state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ibus_uart_tx.sv
// io-bus UART transmitter: words written to the data window are queued and sent
// as two 8N1 bytes, low byte first. DIV and STATUS registers sit at the top of
// the window; reads return after a two-stage pipeline.
module ibus_uart_tx
  import ibus_uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter logic [7:0]  ADDR_HI     = 8'h01,
  parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibus_wen,
  input  logic [15:0] ibus_wadr,
  input  logic [15:0] ibus32_wdata,
  input  logic        ibus_ren,
  input  logic [15:0] ibus_radr,
  output logic [15:0] ibus32_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            wr_hit, data_wr, div_wr, status_wr, rd_hit;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [15:0]     fifo_rdata;
  logic [CntW-1:0] fifo_count;

  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;
  logic [15:0] status;
  logic [15:0] rd1_q, rd1_d, rdata_q;

  logic [1:0]  state_q, state_d;
  logic        byte_sel_q, byte_sel_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] baud_q, baud_d;
  logic        bit_end;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

  assign wr_hit    = ibus_wen & (ibus_wadr[15:8] == ADDR_HI);
  assign data_wr   = wr_hit & (ibus_wadr[7:0] < OFS_DIV);
  assign div_wr    = wr_hit & (ibus_wadr[7:0] == OFS_DIV);
  assign status_wr = wr_hit & (ibus_wadr[7:0] == OFS_STATUS);
  assign rd_hit    = ibus_ren & (ibus_radr[15:8] == ADDR_HI);

  ibus_sync_fifo #(
    .Depth (DEPTH),
    .Width (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (data_wr),
    .wdata_i (ibus32_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Register writes; a dropped word beats a same-edge STATUS clear.
  always_comb begin
    ovf_d = ovf_q;
    if (status_wr) ovf_d = 1'b0;
    if (data_wr && fifo_full) ovf_d = 1'b1;
    div_d = div_q;
    if (div_wr) div_d = clamp_div(ibus32_wdata);
  end

  // Read mux into the first pipeline stage, sampling current register state.
  always_comb begin
    status                 = '0;
    status[ST_OVF]         = ovf_q;
    status[ST_FULL]        = fifo_full;
    status[ST_EMPTY]       = fifo_empty;
    status[ST_BUSY]        = busy_q;
    status[ST_CNT_W-1:0]   = ST_CNT_W'(fifo_count);
    rd1_d = '0;
    if (rd_hit) begin
      if (ibus_radr[7:0] == OFS_DIV)         rd1_d = div_q;
      else if (ibus_radr[7:0] == OFS_STATUS) rd1_d = status;
    end
  end

  assign bit_end = (baud_q == '0);

  // Serializer: start, 8 data bits LSB first, stop; two bytes per popped word.
  always_comb begin
    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    bit_cnt_d  = bit_cnt_q;
    hold_d     = hold_q;
    baud_d     = bit_end ? (div_q - 16'd1) : (baud_q - 16'd1);
    fifo_pop   = 1'b0;
    case (state_q)
      StIdle: begin
        baud_d = div_q - 16'd1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          hold_d     = fifo_rdata;
          byte_sel_d = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_cnt_d = 3'd0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) state_d = StStop;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      default: begin
        if (bit_end) begin
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            state_d    = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
    endcase
    // Line level follows the state being entered so uart_tx is a clean flop.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = hold_d[{byte_sel_d, bit_cnt_d}];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != StIdle) | ~fifo_empty;
  end

  // All block state; reset returns the line to idle on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      div_q      <= DIV_DEFAULT;
      rd1_q      <= '0;
      rdata_q    <= '0;
      state_q    <= StIdle;
      byte_sel_q <= 1'b0;
      bit_cnt_q  <= '0;
      hold_q     <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      div_q      <= div_d;
      rd1_q      <= rd1_d;
      rdata_q    <= rd1_q;
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign ibus32_rdata = rdata_q;
  assign uart_tx      = tx_q;
  assign tx_busy      = busy_q;

endmodule

// File: tb/tb_ibus_uart_tx.sv
// Bench for ibus_uart_tx: a queue-and-frame reference model checks every cycle,
// a register vector table, hand sequences for frame timing, overflow, read
// latency, clamping, reset and address decode, then random traffic.
module tb_ibus_uart_tx;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ibus_wen = 1'b0;
  logic [15:0] ibus_wadr = '0;
  logic [15:0] ibus32_wdata = '0;
  logic        ibus_ren = 1'b0;
  logic [15:0] ibus_radr = '0;
  logic [15:0] ibus32_rdata;
  logic        uart_tx;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  ibus_uart_tx #(
    .DEPTH       (DEPTH),
    .ADDR_HI     (8'h01),
    .DIV_DEFAULT (16'd434)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ibus_wen     (ibus_wen),
    .ibus_wadr    (ibus_wadr),
    .ibus32_wdata (ibus32_wdata),
    .ibus_ren     (ibus_ren),
    .ibus_radr    (ibus_radr),
    .ibus32_rdata (ibus32_rdata),
    .uart_tx      (uart_tx),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  // Reference model: word queue, flags, and the current frame as 20 line levels.
  logic [15:0] m_q[$];
  logic        m_ovf;
  logic [15:0] m_div;
  logic        m_busy;
  bit          m_active;
  int          m_idx;
  int          m_rem;
  logic [19:0] m_bits;
  logic [15:0] m_rd1, m_rd2;

  function automatic logic [19:0] frame_bits(input logic [15:0] w);
    return {1'b1, w[15:8], 1'b0, 1'b1, w[7:0], 1'b0};
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    int n;
    n = m_q.size();
    if (a[15:8] != 8'h01) return 16'h0000;
    if (a[7:0] == 8'hFE) return m_div;
    if (a[7:0] == 8'hFF) return {m_ovf, 1'(n == DEPTH), 1'(n == 0), m_busy, 12'(n)};
    return 16'h0000;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input bit r, input bit we, input logic [15:0] wa, input logic [15:0] wd,
                      input bit re, input logic [15:0] ra);
    int sz;
    bit was_active;
    logic [15:0] rv;
    rst = r; ibus_wen = we; ibus_wadr = wa; ibus32_wdata = wd;
    ibus_ren = re; ibus_radr = ra;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0; m_div = 16'd434; m_busy = 1'b0; m_active = 0;
      m_idx = 0; m_rem = 0; m_rd1 = '0; m_rd2 = '0;
    end else begin
      rv = re ? m_read(ra) : 16'h0000;
      m_rd2 = m_rd1;
      m_rd1 = rv;
      sz = m_q.size();
      was_active = m_active;
      m_busy = was_active || (sz != 0);
      if (was_active) begin
        m_rem--;
        if (m_rem == 0) begin
          m_idx++;
          if (m_idx == 20) m_active = 0;
          else m_rem = m_div;
        end
      end else if (sz != 0) begin
        m_bits = frame_bits(m_q.pop_front());
        m_active = 1; m_idx = 0; m_rem = m_div;
      end
      if (we && wa[15:8] == 8'h01) begin
        if (wa[7:0] == 8'hFE) m_div = (wd < 16'd2) ? 16'd2 : wd;
        else if (wa[7:0] == 8'hFF) m_ovf = 1'b0;
        else if (sz < DEPTH) m_q.push_back(wd);
        else m_ovf = 1'b1;
      end
    end
    #1;
    chk("tx", 16'(uart_tx), 16'(m_active ? m_bits[m_idx] : 1'b1));
    chk("busy", 16'(tx_busy), 16'(m_busy));
    chk("rdata", ibus32_rdata, m_rd2);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(0, 1, a, d, 0, 16'h0);
  endtask
  task automatic rd(input logic [15:0] a);
    step(0, 0, 16'h0, 16'h0, 1, a);
  endtask
  task automatic idle();
    step(0, 0, 16'h0, 16'h0, 0, 16'h0);
  endtask
  task automatic do_reset();
    step(1, 0, 16'h0, 16'h0, 0, 16'h0);
  endtask

  function automatic logic [15:0] rand_adr();
    int c;
    logic [7:0] hi;
    c = $urandom_range(0, 9);
    if (c < 7) return {8'h01, 8'($urandom_range(0, 253))};
    if (c == 7) return 16'h01FE;
    if (c == 8) return 16'h01FF;
    hi = 8'($urandom_range(0, 255));
    if (hi == 8'h01) hi = 8'h02;
    return {hi, 8'($urandom)};
  endfunction

  typedef struct {
    logic [15:0] wadr;
    logic [15:0] wdata;
    logic [15:0] radr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [0:19] pat;
    int lowrun;
    logic [15:0] wa;

    vecs[0] = '{16'h01FE, 16'h0000, 16'h01FE, 16'h0002};
    vecs[1] = '{16'h01FE, 16'h0001, 16'h01FE, 16'h0002};
    vecs[2] = '{16'h01FE, 16'h0002, 16'h01FE, 16'h0002};
    vecs[3] = '{16'h01FE, 16'h0003, 16'h01FE, 16'h0003};
    vecs[4] = '{16'h01FE, 16'hFFFF, 16'h01FE, 16'hFFFF};
    vecs[5] = '{16'h01FE, 16'h01B2, 16'h01FE, 16'h01B2};
    vecs[6] = '{16'h02FE, 16'h0005, 16'h01FE, 16'h01B2};
    vecs[7] = '{16'h03FF, 16'h0000, 16'h01FF, 16'h2000};
    vecs[8] = '{16'h01FE, 16'h0010, 16'h0150, 16'h0000};
    vecs[9] = '{16'h01FE, 16'h0011, 16'h11FE, 16'h0000};

    // Reset state.
    do_reset();
    do_reset();
    chk("reset_tx", 16'(uart_tx), 16'h0001);
    chk("reset_busy", 16'(tx_busy), 16'h0000);
    chk("reset_rdata", ibus32_rdata, 16'h0000);

    // Register vector table: write, read, then compare two cycles later.
    foreach (vecs[i]) begin
      wr(vecs[i].wadr, vecs[i].wdata);
      rd(vecs[i].radr);
      idle();
      chk($sformatf("vec%0d", i), ibus32_rdata, vecs[i].exp);
    end

    // Frame timing: DIV=4, word 0x4142, low byte then high byte.
    do_reset();
    wr(16'h01FE, 16'h0004);
    wr(16'h0100, 16'h4142);
    pat = 20'b0_01000010_1_0_10000010_1;
    for (int k = 0; k < 82; k++) begin
      idle();
      if (k < 80) chk("frame_tx", 16'(uart_tx), 16'(pat[k / 4]));
      if (k == 80) chk("frame_idle", 16'(uart_tx), 16'h0001);
      if (k <= 80) chk("frame_busy", 16'(tx_busy), 16'h0001);
      if (k == 81) chk("busy_drop", 16'(tx_busy), 16'h0000);
    end

    // Burst of DEPTH+3 words at a slow bit rate: overflow and full.
    do_reset();
    wr(16'h01FE, 16'd1000);
    for (int i = 0; i < DEPTH + 3; i++) wr(16'h0100 + 16'(i), 16'($urandom));
    rd(16'h01FF);
    idle();
    chk("burst_status", ibus32_rdata, 16'hD010);
    wr(16'h01FF, 16'h1234);
    rd(16'h01FF);
    idle();
    chk("ovf_clear", ibus32_rdata, 16'h5010);

    // Back-to-back pipelined reads.
    do_reset();
    wr(16'h01FE, 16'h0004);
    rd(16'h01FE);
    rd(16'h01FF);
    chk("b2b_first", ibus32_rdata, 16'h0004);
    rd(16'h0200);
    chk("b2b_second", ibus32_rdata, 16'h2000);
    idle();
    chk("b2b_third", ibus32_rdata, 16'h0000);

    // DIV=0 clamps to 2; start bit measured in cycles.
    wr(16'h01FE, 16'h0000);
    rd(16'h01FE);
    idle();
    chk("div_clamp", ibus32_rdata, 16'h0002);
    wr(16'h0100, 16'h00FF);
    lowrun = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (uart_tx == 1'b0) lowrun++;
      else if (lowrun > 0) break;
    end
    chk("bit_time", 16'(lowrun), 16'd2);
    for (int i = 0; i < 50; i++) idle();

    // Reset while shifting data bits of the first byte.
    wr(16'h01FE, 16'h0004);
    wr(16'h0100, 16'h4142);
    for (int k = 0; k < 7; k++) idle();
    do_reset();
    chk("rst_tx", 16'(uart_tx), 16'h0001);
    chk("rst_busy", 16'(tx_busy), 16'h0000);
    rd(16'h01FF);
    idle();
    chk("rst_status", ibus32_rdata, 16'h2000);
    rd(16'h01FE);
    idle();
    chk("rst_div", ibus32_rdata, 16'h01B2);

    // Writes to another block are ignored.
    wr(16'h02FE, 16'h0007);
    wr(16'h0200, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("foreign_tx", 16'(uart_tx), 16'h0001);
    end
    rd(16'h01FE);
    idle();
    chk("foreign_div", ibus32_rdata, 16'h01B2);

    // Random traffic against the model.
    do_reset();
    wr(16'h01FE, 16'h0002);
    for (int n = 0; n < 4000; n++) begin
      bit we, re;
      logic [15:0] wd;
      we = ($urandom_range(0, 9) < 3);
      re = ($urandom_range(0, 1) == 1);
      wa = rand_adr();
      wd = (wa == 16'h01FE) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      step(($urandom_range(0, 999) == 0), we, wa, wd, re, rand_adr());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
